btb_assoc: RTL and testbench

Parametrised N-way set-associative branch target buffer with per-entry 2-bit saturating direction counters, round-robin replacement, bulk flush and branch/mispredict statistics. It sits beside the IF-stage PC register to supply a next-PC prediction each cycle, and takes resolved branch outcomes from the EX stage. It replaces the single-way, valid-bit-only BTB, and keeps that block's `predict_error_type` encoding.

---
 rtl/btb_assoc_if.sv | 34 +++
 rtl/btb_assoc.sv | 167 ++++++++++++++++
 tb/tb_btb_assoc.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/btb_assoc_if.sv
// IF/EX-side bundle for the set-associative BTB.
// master drives PCs and resolved outcomes; slave returns predictions.
interface btb_assoc_if;
  logic [31:0] PCF;
  logic [31:0] PCE;
  logic        is_branch;
  logic        is_taken_ex;
  logic        is_taken_if;
  logic [31:0] set_target_addr;
  logic        flush;
  logic        btb_hit;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic [1:0]  predict_error_type;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output PCF, PCE, is_branch, is_taken_ex,
    output is_taken_if, set_target_addr, flush,
    input  btb_hit, predict_taken, predict_target,
    input  predict_error_type, mispredict,
    input  branch_cnt, mispredict_cnt
  );

  modport slave (
    input  PCF, PCE, is_branch, is_taken_ex,
    input  is_taken_if, set_target_addr, flush,
    output btb_hit, predict_taken, predict_target,
    output predict_error_type, mispredict,
    output branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/btb_assoc.sv
// N-way set-associative BTB with 2-bit direction counters,
// round-robin replacement, bulk flush and branch statistics.
module btb_assoc #(
  parameter int SET_INDEX_LEN = 6,
  parameter int WAYS          = 2
) (
  input logic       clk,
  input logic       rst_n,
  btb_assoc_if.slave bus
);
  localparam int SETS = 1 << SET_INDEX_LEN;
  localparam int TW   = 30 - SET_INDEX_LEN;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [SET_INDEX_LEN-1:0] idx_t;
  typedef logic [TW-1:0]            tag_t;
  typedef logic [WW-1:0]            way_t;

  logic        valid_q [SETS][WAYS];
  tag_t        tag_q   [SETS][WAYS];
  logic [31:0] tgt_q   [SETS][WAYS];
  logic [1:0]  ctr_q   [SETS][WAYS];
  way_t        rr_q    [SETS];

  logic [31:0] bcnt_q, bcnt_d;
  logic [31:0] mcnt_q, mcnt_d;

  idx_t f_idx, e_idx;
  tag_t f_tag, e_tag;

  assign f_idx = bus.PCF[SET_INDEX_LEN+1:2];
  assign f_tag = bus.PCF[31:SET_INDEX_LEN+2];
  assign e_idx = bus.PCE[SET_INDEX_LEN+1:2];
  assign e_tag = bus.PCE[31:SET_INDEX_LEN+2];

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{bus.PCF[1:0], bus.PCE[1:0]};

  logic f_hit;
  way_t f_way;

  always_comb begin
    f_hit = 1'b0;
    f_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag) begin
        f_hit = 1'b1;
        f_way = way_t'(w);
      end
    end
  end

  logic e_hit;
  way_t e_way;
  logic inv_found;
  way_t inv_way;
  way_t victim;

  // Descending scan leaves the lowest-numbered invalid way.
  always_comb begin
    e_hit     = 1'b0;
    e_way     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[e_idx][w] && tag_q[e_idx][w] == e_tag) begin
        e_hit = 1'b1;
        e_way = way_t'(w);
      end
      if (!valid_q[e_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = way_t'(w);
      end
    end
    victim = inv_found ? inv_way : rr_q[e_idx];
  end

  logic [1:0] f_ctr;
  assign f_ctr = ctr_q[f_idx][f_way];

  assign bus.btb_hit        = f_hit;
  assign bus.predict_taken  = f_hit & f_ctr[1];
  assign bus.predict_target = (f_hit & f_ctr[1]) ?
                              tgt_q[f_idx][f_way] :
                              bus.PCF + 32'd4;

  logic mis;
  assign mis = bus.is_branch &
               (bus.is_taken_ex ^ bus.is_taken_if);
  assign bus.mispredict = mis;

  always_comb begin
    bus.predict_error_type = 2'b00;
    if (bus.is_branch) begin
      unique case (1'b1)
        bus.is_taken_if &  bus.is_taken_ex:
          bus.predict_error_type = 2'b00;
        !bus.is_taken_if & !bus.is_taken_ex:
          bus.predict_error_type = 2'b01;
        !bus.is_taken_if &  bus.is_taken_ex:
          bus.predict_error_type = 2'b10;
        default:
          bus.predict_error_type = 2'b11;
      endcase
    end
  end

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (bus.is_branch) begin
      bcnt_d = bcnt_q + 32'd1;
      if (mis) mcnt_d = mcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign bus.branch_cnt     = bcnt_q;
  assign bus.mispredict_cnt = mcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
          ctr_q[s][w]   <= 2'b01;
        end
      end
    end else if (bus.flush) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
        end
      end
    end else if (bus.is_branch) begin
      if (e_hit) begin
        if (bus.is_taken_ex) begin
          tgt_q[e_idx][e_way] <= bus.set_target_addr;
          if (ctr_q[e_idx][e_way] != 2'b11)
            ctr_q[e_idx][e_way] <= ctr_q[e_idx][e_way] + 2'd1;
        end else if (ctr_q[e_idx][e_way] != 2'b00) begin
          ctr_q[e_idx][e_way] <= ctr_q[e_idx][e_way] - 2'd1;
        end
      end else if (bus.is_taken_ex) begin
        valid_q[e_idx][victim] <= 1'b1;
        tag_q[e_idx][victim]   <= e_tag;
        tgt_q[e_idx][victim]   <= bus.set_target_addr;
        ctr_q[e_idx][victim]   <= 2'b10;
        if (!inv_found && WAYS > 1)
          rr_q[e_idx] <= rr_q[e_idx] + way_t'(1);
      end
    end
  end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed vector bench for btb_assoc (WAYS=2, SET_INDEX_LEN=6).
// Lookups are checked before the edge that applies each vector's update.
module tb_btb_assoc;
  logic clk;
  logic rst_n;

  btb_assoc_if bus ();

  btb_assoc #(.SET_INDEX_LEN(6), .WAYS(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pcf;
    logic        br;
    logic [31:0] pce;
    logic        tex;
    logic        tif;
    logic [31:0] tgt;
    logic        fl;
    logic        hit;
    logic        pt;
    logic [31:0] ptgt;
    logic [1:0]  err;
    logic        mis;
  } vec_t;

  function automatic vec_t mk(
    logic [31:0] pcf, logic br, logic [31:0] pce,
    logic tex, logic tif, logic [31:0] tgt, logic fl,
    logic hit, logic pt, logic [31:0] ptgt,
    logic [1:0] err, logic mis);
    vec_t v;
    v.pcf = pcf; v.br = br; v.pce = pce;
    v.tex = tex; v.tif = tif; v.tgt = tgt; v.fl = fl;
    v.hit = hit; v.pt = pt; v.ptgt = ptgt;
    v.err = err; v.mis = mis;
    return v;
  endfunction

  vec_t vt [23];

  task automatic drive(input vec_t v);
    bus.PCF             = v.pcf;
    bus.is_branch       = v.br;
    bus.PCE             = v.pce;
    bus.is_taken_ex     = v.tex;
    bus.is_taken_if     = v.tif;
    bus.set_target_addr = v.tgt;
    bus.flush           = v.fl;
  endtask

  initial begin
    vec_t idle;
    // pcf br pce tex tif tgt fl | hit pt ptgt err mis
    vt[0]  = mk(32'h100,0,0,0,0,0,0,         0,0,32'h104, 2'b00,0);
    vt[1]  = mk(32'h100,1,32'h100,1,0,32'h200,0, 0,0,32'h104, 2'b10,1);
    vt[2]  = mk(32'h100,0,0,0,0,0,0,         1,1,32'h200, 2'b00,0);
    vt[3]  = mk(32'h100,1,32'h100,0,1,0,0,   1,1,32'h200, 2'b11,1);
    vt[4]  = mk(32'h100,1,32'h100,0,0,0,0,   1,0,32'h104, 2'b01,0);
    vt[5]  = mk(32'h100,0,0,0,0,0,0,         1,0,32'h104, 2'b00,0);
    vt[6]  = mk(32'h200,1,32'h200,1,1,32'h1200,0, 0,0,32'h204, 2'b00,0);
    vt[7]  = mk(32'h300,1,32'h300,1,0,32'h1300,0, 0,0,32'h304, 2'b10,1);
    vt[8]  = mk(32'h100,0,0,0,0,0,0,         0,0,32'h104, 2'b00,0);
    vt[9]  = mk(32'h200,0,0,0,0,0,0,         1,1,32'h1200,2'b00,0);
    vt[10] = mk(32'h300,0,0,0,0,0,0,         1,1,32'h1300,2'b00,0);
    vt[11] = mk(32'h400,1,32'h400,1,1,32'h1400,0, 0,0,32'h404, 2'b00,0);
    vt[12] = mk(32'h200,0,0,0,0,0,0,         0,0,32'h204, 2'b00,0);
    vt[13] = mk(32'h300,0,0,0,0,0,0,         1,1,32'h1300,2'b00,0);
    vt[14] = mk(32'h400,0,0,0,0,0,0,         1,1,32'h1400,2'b00,0);
    vt[15] = mk(32'h300,1,32'h300,1,1,32'h2300,0, 1,1,32'h1300,2'b00,0);
    vt[16] = mk(32'h300,0,0,0,0,0,0,         1,1,32'h2300,2'b00,0);
    vt[17] = mk(32'h300,1,32'h500,1,0,32'h1500,1, 1,1,32'h2300,2'b10,1);
    vt[18] = mk(32'h500,0,0,0,0,0,0,         0,0,32'h504, 2'b00,0);
    vt[19] = mk(32'h300,0,0,0,0,0,0,         0,0,32'h304, 2'b00,0);
    vt[20] = mk(32'h400,0,0,0,0,0,0,         0,0,32'h404, 2'b00,0);
    vt[21] = mk(32'h108,1,32'h10B,1,1,32'h3000,0, 0,0,32'h10C, 2'b00,0);
    vt[22] = mk(32'h108,0,0,0,0,0,0,         1,1,32'h3000,2'b00,0);
    idle   = mk(32'h100,0,0,0,0,0,0,         0,0,0,2'b00,0);

    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    cmp("rst_hit",  {31'd0, bus.btb_hit}, 32'd0);
    cmp("rst_ptgt", bus.predict_target, 32'h104);
    cmp("rst_bcnt", bus.branch_cnt, 32'd0);
    cmp("rst_mcnt", bus.mispredict_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      cmp($sformatf("v%0d_hit", i), {31'd0, bus.btb_hit},
          {31'd0, vt[i].hit});
      cmp($sformatf("v%0d_pt", i), {31'd0, bus.predict_taken},
          {31'd0, vt[i].pt});
      cmp($sformatf("v%0d_ptgt", i), bus.predict_target, vt[i].ptgt);
      cmp($sformatf("v%0d_err", i), {30'd0, bus.predict_error_type},
          {30'd0, vt[i].err});
      cmp($sformatf("v%0d_mis", i), {31'd0, bus.mispredict},
          {31'd0, vt[i].mis});
    end
    @(negedge clk);
    drive(idle);
    #1;
    cmp("seq_bcnt", bus.branch_cnt, 32'd9);
    cmp("seq_mcnt", bus.mispredict_cnt, 32'd4);

    // Asynchronous reset in the middle of a pending update.
    @(negedge clk);
    drive(mk(32'h108,1,32'h600,1,0,32'h1600,0, 0,0,0,2'b00,0));
    #2;
    rst_n = 1'b0;
    #1;
    cmp("ar_hit",  {31'd0, bus.btb_hit}, 32'd0);
    cmp("ar_ptgt", bus.predict_target, 32'h10C);
    cmp("ar_bcnt", bus.branch_cnt, 32'd0);
    cmp("ar_mcnt", bus.mispredict_cnt, 32'd0);
    cmp("ar_err",  {30'd0, bus.predict_error_type}, 32'd2);
    cmp("ar_mis",  {31'd0, bus.mispredict}, 32'd1);
    @(negedge clk);
    bus.PCF = 32'h600;
    #1;
    cmp("ar_noalloc", {31'd0, bus.btb_hit}, 32'd0);
    cmp("ar_bcnt2", bus.branch_cnt, 32'd0);

    // First edge after release allocates.
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(32'h100,1,32'h100,1,0,32'h200,0, 0,0,0,2'b00,0));
    @(negedge clk);
    drive(idle);
    #1;
    cmp("rl_pt",   {31'd0, bus.predict_taken}, 32'd1);
    cmp("rl_ptgt", bus.predict_target, 32'h200);
    cmp("rl_bcnt", bus.branch_cnt, 32'd1);
    cmp("rl_mcnt", bus.mispredict_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
